// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencing controller: vector widths,
// stage indices, stall/jump polarity constants, FSM state encoding and the
// stall-merge helper.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int STALL_W_DEF = 6;

    // Stage indices into the stall vector
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    // Polarity constants used by the controller and its consumers
    localparam logic STALL    = 1'b1;
    localparam logic NO_STALL = 1'b0;
    localparam logic JUMP     = 1'b1;
    localparam logic NO_JUMP  = 1'b0;

    typedef logic [STALL_W_DEF-1:0] stall_t;
    typedef logic [ADDR_W_DEF-1:0]  addr_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    // Merge stage stall requests: the highest requesting stage stalls itself
    // and everything upstream of it. req = {mem, ex, id, if}. WB never stalls.
    function automatic stall_t merge_stalls(input logic [3:0] req);
        stall_t v;
        if (req[3]) begin
            v = 6'b011111;
        end else if (req[2]) begin
            v = 6'b001111;
        end else if (req[1]) begin
            v = 6'b000111;
        end else if (req[0]) begin
            v = 6'b000011;
        end else begin
            v = 6'b000000;
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle between the pipeline stages and the sequencing controller.
//   master : the controller (consumes stage requests, drives stall/flush/PC)
//   slave  : the pipeline side (drives requests, consumes stall/flush/PC)
// Signals: rdy_in, stallReq{IF,ID,EX,MEM}_in, jump_in, jumpTarget_in,
//          ifBusy_in, ifDone_in, stall_out, pcJump_out, pcRedirect_out,
//          pcTarget_out, ifDiscard_out.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int STALL_W = STALL_W_DEF
);
    logic               rdy_in;
    logic               stallReqIF_in;
    logic               stallReqID_in;
    logic               stallReqEX_in;
    logic               stallReqMEM_in;
    logic               jump_in;
    logic [ADDR_W-1:0]  jumpTarget_in;
    logic               ifBusy_in;
    logic               ifDone_in;
    logic [STALL_W-1:0] stall_out;
    logic               pcJump_out;
    logic               pcRedirect_out;
    logic [ADDR_W-1:0]  pcTarget_out;
    logic               ifDiscard_out;

    modport master (
        input  rdy_in, stallReqIF_in, stallReqID_in, stallReqEX_in,
               stallReqMEM_in, jump_in, jumpTarget_in, ifBusy_in, ifDone_in,
        output stall_out, pcJump_out, pcRedirect_out, pcTarget_out,
               ifDiscard_out
    );

    modport slave (
        output rdy_in, stallReqIF_in, stallReqID_in, stallReqEX_in,
               stallReqMEM_in, jump_in, jumpTarget_in, ifBusy_in, ifDone_in,
        input  stall_out, pcJump_out, pcRedirect_out, pcTarget_out,
               ifDiscard_out
    );
endinterface

// File: rtl/pipe_perf_cnt.sv
// ---------------------------------------------------------------------------
// pipe_perf_cnt
// Performance counters for the pipeline controller. Only present when the
// PIPE_PERF_EN macro is defined; otherwise this file contributes nothing.
// Ports:
//   clk_in          clock
//   rst_in          async active-low reset
//   stall_inc_in    count this cycle as a stalled cycle
//   flush_inc_in    count this cycle as an accepted jump
//   stallCycles_out free-running stalled-cycle count (wraps)
//   flushCount_out  free-running accepted-jump count (wraps)
// ---------------------------------------------------------------------------
`ifdef PIPE_PERF_EN
module pipe_perf_cnt (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_inc_in,
    input  logic        flush_inc_in,
    output logic [31:0] stallCycles_out,
    output logic [31:0] flushCount_out
);
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Counter registers; natural 32-bit wrap on overflow
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (stall_inc_in) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (flush_inc_in) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign stallCycles_out = stall_cnt_r;
    assign flushCount_out  = flush_cnt_r;
endmodule
`endif

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Pipeline sequencing controller for the 5-stage core. Merges stage stall
// requests into the shared stall vector, accepts branch/jump resolutions from
// EX, drives the flush line and the PC redirect. When IF has an uncancellable
// fetch in flight, the redirect is held in a pending register until the fetch
// returns, and the returning instruction is discarded.
// Ports:
//   clk_in   system clock, rising edge
//   rst_in   asynchronous active-low reset
//   bus      pipe_ctrl_if.master (stage requests in; stall/flush/PC out)
//   stallCycles_out, flushCount_out  (only with PIPE_PERF_EN defined)
// Optional feature macro: PIPE_PERF_EN
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int STALL_W = STALL_W_DEF
)(
    input  logic        clk_in,
    input  logic        rst_in,
    pipe_ctrl_if.master bus
`ifdef PIPE_PERF_EN
    ,
    output logic [31:0] stallCycles_out,
    output logic [31:0] flushCount_out
`endif
);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [ADDR_W-1:0]  tgt_r;
    logic [ADDR_W-1:0]  tgt_nxt_s;
    logic [3:0]         req_s;
    logic [STALL_W-1:0] merge_s;
    logic               jump_acc_s;
    logic [STALL_W-1:0] stall_s;
    logic               pc_jump_s;
    logic               redirect_s;
    logic [ADDR_W-1:0]  target_s;
    logic               discard_s;

    assign req_s   = {bus.stallReqMEM_in, bus.stallReqEX_in,
                      bus.stallReqID_in, bus.stallReqIF_in};
    assign merge_s = merge_stalls(req_s);

    // A stalled EX cannot hand over its jump; it re-presents it next cycle
    assign jump_acc_s = bus.rdy_in & bus.jump_in & (merge_s[STG_EX] == NO_STALL);

    // Output decode and next-state logic
    always_comb begin
        state_nxt_s = state_r;
        tgt_nxt_s   = tgt_r;
        stall_s     = merge_s;
        pc_jump_s   = NO_JUMP;
        redirect_s  = 1'b0;
        target_s    = tgt_r;
        discard_s   = 1'b0;
        if (!rst_in) begin
            // Outputs are forced quiet for the whole reset window, not just
            // after the next edge.
            stall_s  = {STALL_W{1'b0}};
            target_s = {ADDR_W{1'b0}};
        end else if (!bus.rdy_in) begin
            stall_s = {STALL_W{1'b1}};
        end else begin
            pc_jump_s = jump_acc_s ? JUMP : NO_JUMP;
            case (state_r)
                ST_IDLE: begin
                    if (jump_acc_s) begin
                        if (!bus.ifBusy_in || bus.ifDone_in) begin
                            redirect_s = 1'b1;
                            target_s   = bus.jumpTarget_in;
                            discard_s  = bus.ifDone_in;
                        end else begin
                            tgt_nxt_s   = bus.jumpTarget_in;
                            state_nxt_s = ST_PEND;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PEND: begin
                    discard_s = 1'b1;
                    // Keep PC and IF/ID frozen while the stale fetch drains
                    stall_s   = merge_s | {{(STALL_W-2){1'b0}}, 2'b11};
                    if (jump_acc_s) begin
                        // A newer jump supersedes the pending target
                        tgt_nxt_s   = bus.jumpTarget_in;
                        state_nxt_s = ST_PEND;
                    end else if (bus.ifDone_in) begin
                        redirect_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PEND;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state and pending-target register; both hold while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= ST_IDLE;
            tgt_r   <= {ADDR_W{1'b0}};
        end else if (bus.rdy_in) begin
            state_r <= state_nxt_s;
            tgt_r   <= tgt_nxt_s;
        end else begin
            state_r <= state_r;
            tgt_r   <= tgt_r;
        end
    end

    assign bus.stall_out      = stall_s;
    assign bus.pcJump_out     = pc_jump_s;
    assign bus.pcRedirect_out = redirect_s;
    assign bus.pcTarget_out   = target_s;
    assign bus.ifDiscard_out  = discard_s;

`ifdef PIPE_PERF_EN
    logic stall_inc_s;

    assign stall_inc_s = stall_s[STG_PC] & bus.rdy_in;

    pipe_perf_cnt u_perf (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .stall_inc_in    (stall_inc_s),
        .flush_inc_in    (jump_acc_s),
        .stallCycles_out (stallCycles_out),
        .flushCount_out  (flushCount_out)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed-vector bench for pipe_ctrl. Each step drives inputs shortly after
// the rising edge and queues the hand-computed outputs; a monitor on the
// falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    typedef struct {
        logic [5:0]  stall;
        logic        jmp;
        logic        redir;
        logic [31:0] tgt;
        logic        disc;
        string       name;
    } exp_t;

    localparam logic [3:0] R_NONE = 4'b0000;
    localparam logic [3:0] R_IF   = 4'b0001;
    localparam logic [3:0] R_ID   = 4'b0010;
    localparam logic [3:0] R_EX   = 4'b0100;
    localparam logic [3:0] R_MEM  = 4'b1000;

    logic clk_in;
    logic rst_in;
    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

`ifdef PIPE_PERF_EN
    logic [31:0] stallCycles_out;
    logic [31:0] flushCount_out;
`endif

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .bus             (bus)
`ifdef PIPE_PERF_EN
        ,
        .stallCycles_out (stallCycles_out),
        .flushCount_out  (flushCount_out)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Scoreboard monitor: one expected record per cycle, checked mid-cycle
    always @(negedge clk_in) begin : mon
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus.stall_out, bus.pcJump_out, bus.pcRedirect_out,
                 bus.pcTarget_out, bus.ifDiscard_out} !==
                {e.stall, e.jmp, e.redir, e.tgt, e.disc}) begin
                n_bad++;
                $display("FAIL %s: got stall=%b jump=%b redir=%b tgt=%h disc=%b, expected stall=%b jump=%b redir=%b tgt=%h disc=%b",
                         e.name, bus.stall_out, bus.pcJump_out,
                         bus.pcRedirect_out, bus.pcTarget_out,
                         bus.ifDiscard_out, e.stall, e.jmp, e.redir,
                         e.tgt, e.disc);
            end
        end
    end

    task automatic step(input logic rst, input logic rdy, input logic [3:0] req,
                        input logic jmp, input logic [31:0] tgt,
                        input logic busy, input logic done,
                        input logic [5:0] e_stall, input logic e_jmp,
                        input logic e_redir, input logic [31:0] e_tgt,
                        input logic e_disc, input string nm);
        exp_t e;
        @(posedge clk_in);
        #1;
        rst_in             = rst;
        bus.rdy_in         = rdy;
        bus.stallReqMEM_in = req[3];
        bus.stallReqEX_in  = req[2];
        bus.stallReqID_in  = req[1];
        bus.stallReqIF_in  = req[0];
        bus.jump_in        = jmp;
        bus.jumpTarget_in  = tgt;
        bus.ifBusy_in      = busy;
        bus.ifDone_in      = done;
        e.stall = e_stall;
        e.jmp   = e_jmp;
        e.redir = e_redir;
        e.tgt   = e_tgt;
        e.disc  = e_disc;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_in             = 1'b0;
        bus.rdy_in         = 1'b1;
        bus.stallReqMEM_in = 1'b1;
        bus.stallReqEX_in  = 1'b0;
        bus.stallReqID_in  = 1'b0;
        bus.stallReqIF_in  = 1'b0;
        bus.jump_in        = 1'b1;
        bus.jumpTarget_in  = 32'h0000_1234;
        bus.ifBusy_in      = 1'b1;
        bus.ifDone_in      = 1'b1;

        //    rst   rdy   req     jmp   target        busy  done  | stall      jmp   redir tgt           disc
        step(1'b0, 1'b1, R_MEM,  1'b1, 32'h0000_1234, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "reset_hold");
        step(1'b1, 1'b1, R_NONE, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "idle");
        step(1'b1, 1'b1, R_ID,   1'b0, 32'h0000_0000, 1'b0, 1'b0, 6'b000111, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "stall_id");
        step(1'b1, 1'b1, R_ID | R_MEM, 1'b0, 32'h0, 1'b0, 1'b0, 6'b011111, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "stall_mem_id");
        step(1'b1, 1'b1, R_IF,   1'b0, 32'h0000_0000, 1'b0, 1'b0, 6'b000011, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "stall_if");
        step(1'b1, 1'b1, R_EX | R_IF, 1'b0, 32'h0, 1'b0, 1'b0, 6'b001111, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "stall_ex");
        step(1'b1, 1'b1, R_NONE, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "stall_clear");
        step(1'b1, 1'b1, R_NONE, 1'b1, 32'h0000_1040, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 32'h0000_1040, 1'b0, "jump_idle");
        step(1'b1, 1'b1, R_NONE, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "tgt_not_latched");
        step(1'b1, 1'b1, R_NONE, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 6'b000000, 1'b1, 1'b1, 32'h0000_0300, 1'b1, "jump_done_same");
        step(1'b1, 1'b1, R_NONE, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b0, 32'h0000_0000, 1'b0, "jump_defer");
        step(1'b1, 1'b1, R_NONE, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 6'b000011, 1'b0, 1'b0, 32'h0000_0200, 1'b1, "pend_1");
        step(1'b1, 1'b1, R_ID,   1'b0, 32'h0000_0000, 1'b1, 1'b0, 6'b000111, 1'b0, 1'b0, 32'h0000_0200, 1'b1, "pend_2_or");
        step(1'b1, 1'b1, R_NONE, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 6'b000011, 1'b0, 1'b1, 32'h0000_0200, 1'b1, "pend_done");
        step(1'b1, 1'b1, R_NONE, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0000_0200, 1'b0, "back_idle");
        step(1'b1, 1'b1, R_MEM,  1'b1, 32'h0000_0400, 1'b0, 1'b0, 6'b011111, 1'b0, 1'b0, 32'h0000_0200, 1'b0, "jump_blk_mem");
        step(1'b1, 1'b1, R_NONE, 1'b1, 32'h0000_0400, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 32'h0000_0400, 1'b0, "jump_after_mem");
        step(1'b1, 1'b1, R_EX,   1'b1, 32'h0000_0410, 1'b0, 1'b0, 6'b001111, 1'b0, 1'b0, 32'h0000_0200, 1'b0, "jump_blk_ex");
        step(1'b1, 1'b1, R_ID,   1'b1, 32'h0000_0420, 1'b0, 1'b0, 6'b000111, 1'b1, 1'b1, 32'h0000_0420, 1'b0, "jump_id_ok");
        step(1'b1, 1'b0, R_ID,   1'b1, 32'h0000_0430, 1'b0, 1'b0, 6'b111111, 1'b0, 1'b0, 32'h0000_0200, 1'b0, "rdy_low_idle");
        step(1'b1, 1'b1, R_NONE, 1'b1, 32'h0000_0500, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b0, 32'h0000_0200, 1'b0, "jump_defer2");
        step(1'b1, 1'b0, R_NONE, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 6'b111111, 1'b0, 1'b0, 32'h0000_0500, 1'b0, "rdy_low_pend");
        step(1'b1, 1'b1, R_NONE, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 6'b000011, 1'b0, 1'b0, 32'h0000_0500, 1'b1, "pend_held");
        step(1'b1, 1'b1, R_NONE, 1'b1, 32'h0000_0600, 1'b1, 1'b1, 6'b000011, 1'b1, 1'b0, 32'h0000_0500, 1'b1, "pend_rejump");
        step(1'b1, 1'b1, R_NONE, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 6'b000011, 1'b0, 1'b1, 32'h0000_0600, 1'b1, "pend_done2");
        step(1'b1, 1'b1, R_NONE, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0000_0600, 1'b0, "idle2");
        step(1'b1, 1'b1, R_NONE, 1'b1, 32'h0000_0700, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b0, 32'h0000_0600, 1'b0, "jump_defer3");
        step(1'b0, 1'b1, R_ID,   1'b1, 32'h0000_0710, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "reset_mid_pend");
        step(1'b1, 1'b1, R_NONE, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "post_reset_no_redir");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, R_IF, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 6'b000011, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "perf_stall");
        end
        step(1'b1, 1'b1, R_NONE, 1'b1, 32'h0000_0800, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 32'h0000_0800, 1'b0, "perf_jump1");
        step(1'b1, 1'b1, R_NONE, 1'b1, 32'h0000_0900, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 32'h0000_0900, 1'b0, "perf_jump2");
        step(1'b1, 1'b1, R_NONE, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "final_idle");

`ifdef PIPE_PERF_EN
        // Counters cleared by the mid-PEND reset, then 4 stalls and 2 jumps
        n_cmp++;
        if (stallCycles_out !== 32'd4) begin
            n_bad++;
            $display("FAIL perf_stall_cnt: got %0d, expected 4", stallCycles_out);
        end
        n_cmp++;
        if (flushCount_out !== 32'd2) begin
            n_bad++;
            $display("FAIL perf_flush_cnt: got %0d, expected 2", flushCount_out);
        end
`endif

        // Let the monitor drain the last record, bounded to a few cycles
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() != 0) begin
                @(posedge clk_in);
                #1;
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
